// File: rtl/imem_fetch_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the fetch/data memory arbiters.
//   NOP_INSTR      : instruction returned on reset and on a forced completion
//   DEF_*          : default parameter values for the arbiters
//   arb_state_e    : arbiter FSM states (IDLE, WAIT)
//   wrap_inc()     : index increment modulo n
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;

    localparam int unsigned DEF_NUM_CORES = 2;
    localparam int unsigned DEF_ADDR_W    = 32;
    localparam int unsigned DEF_DATA_W    = 32;
    localparam int unsigned DEF_TIMEOUT   = 64;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_e;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/imem_fetch_arbiter_if.sv
// -----------------------------------------------------------------------------
// imem_fetch_arbiter_if
// Bundles the core-side fetch handshake and the memory-side read port.
//   core_req/core_addr          : per-core fetch request and PC
//   core_rdata/core_rvalid      : returned instruction (broadcast) and per-core valid
//   core_stall                  : per-core PC / IF-ID freeze
//   mem_req/mem_addr            : single-cycle read strobe and address
//   mem_rdata/mem_rvalid        : memory read data and valid
//   arb_err                     : sticky timeout flag
// Modports: master = arbiter side, slave = cores + memory side.
// -----------------------------------------------------------------------------
interface imem_fetch_arbiter_if #(
    parameter int unsigned NUM_CORES = 2,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32
);
    logic [NUM_CORES-1:0]        core_req;
    logic [NUM_CORES*ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0]           core_rdata;
    logic [NUM_CORES-1:0]        core_rvalid;
    logic [NUM_CORES-1:0]        core_stall;
    logic                        mem_req;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_rdata;
    logic                        mem_rvalid;
    logic                        arb_err;

    modport master (
        input  core_req, core_addr, mem_rdata, mem_rvalid,
        output core_rdata, core_rvalid, core_stall, mem_req, mem_addr, arb_err
    );

    modport slave (
        output core_req, core_addr, mem_rdata, mem_rvalid,
        input  core_rdata, core_rvalid, core_stall, mem_req, mem_addr, arb_err
    );
endinterface

// File: rtl/imem_fetch_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker: returns the first asserted request at or
// after ptr, wrapping modulo NUM_REQ.
//   req   : request vector
//   ptr   : highest-priority index this cycle
//   valid : at least one request asserted
//   idx   : chosen index (0 when !valid)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    int unsigned       cand;
    logic [IDX_W-1:0]  cand_idx;

    always_comb begin
        valid    = 1'b0;
        idx      = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!valid && req[cand_idx]) begin
                valid = 1'b1;
                idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/imem_fetch_arbiter.sv
// -----------------------------------------------------------------------------
// imem_fetch_arbiter
// Shares one single-ported instruction memory between NUM_CORES fetch units.
// Round-robin grant, one fetch in flight; the winner's instruction is returned
// with a one-cycle core_rvalid pulse. core_stall holds a requesting core until
// its fetch completes.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : imem_fetch_arbiter_if.master (core and memory signals)
// Optional: define IMEM_ARB_TIMEOUT_EN to add a WAIT watchdog that forces a
// NOP completion after TIMEOUT cycles and sets the sticky arb_err flag.
// -----------------------------------------------------------------------------
module imem_fetch_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned NUM_CORES = DEF_NUM_CORES,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    imem_fetch_arbiter_if.master bus
);

    localparam int unsigned IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    arb_state_e           state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     gnt_idx_q, gnt_idx_d;
    logic                 mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]    core_rdata_q, core_rdata_d;
    logic [NUM_CORES-1:0] core_rvalid_q, core_rvalid_d;
    logic                 arb_err_q, arb_err_d;

    logic [NUM_CORES-1:0] eligible;
    logic                 pick_valid;
    logic [IDX_W-1:0]     pick_idx;
    logic [ADDR_W-1:0]    pick_addr;
    logic                 rsp_ok;
    logic                 timeout_hit;
    logic                 wait_done;

`ifdef IMEM_ARB_TIMEOUT_EN
    localparam int unsigned TO_CNT_W = $clog2(TIMEOUT + 1);
    logic [TO_CNT_W-1:0]  to_cnt_q, to_cnt_d;

    assign timeout_hit = (state_q == WAIT) && !bus.mem_rvalid
                         && (to_cnt_q == TO_CNT_W'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // A core completing this cycle still has core_req high; masking it with
    // core_rvalid keeps it from being re-granted on its own stale request.
    assign eligible  = bus.core_req & ~core_rvalid_q;
    assign rsp_ok    = (state_q == WAIT) && bus.mem_rvalid;
    assign wait_done = rsp_ok || timeout_hit;

    rr_arbiter #(
        .NUM_REQ (NUM_CORES),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req   (eligible),
        .ptr   (rr_ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        pick_addr = '0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            if (pick_idx == IDX_W'(k)) begin
                pick_addr = bus.core_addr[k*ADDR_W +: ADDR_W];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            gnt_idx_q     <= '0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            core_rdata_q  <= DATA_W'(NOP_INSTR);
            core_rvalid_q <= '0;
            arb_err_q     <= 1'b0;
`ifdef IMEM_ARB_TIMEOUT_EN
            to_cnt_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            gnt_idx_q     <= gnt_idx_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            core_rdata_q  <= core_rdata_d;
            core_rvalid_q <= core_rvalid_d;
            arb_err_q     <= arb_err_d;
`ifdef IMEM_ARB_TIMEOUT_EN
            to_cnt_q      <= to_cnt_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (pick_valid) state_d = WAIT;
            WAIT: if (wait_done)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic. mem_rvalid seen in IDLE is deliberately dropped.
    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        gnt_idx_d     = gnt_idx_q;
        mem_req_d     = 1'b0;
        mem_addr_d    = mem_addr_q;
        core_rdata_d  = core_rdata_q;
        core_rvalid_d = '0;
        arb_err_d     = arb_err_q;
`ifdef IMEM_ARB_TIMEOUT_EN
        to_cnt_d      = to_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_idx_d  = pick_idx;
                    mem_addr_d = pick_addr;
                    mem_req_d  = 1'b1;
`ifdef IMEM_ARB_TIMEOUT_EN
                    to_cnt_d   = '0;
`endif
                end
            end
            WAIT: begin
                if (rsp_ok) begin
                    core_rdata_d = bus.mem_rdata;
                end else if (timeout_hit) begin
                    core_rdata_d = DATA_W'(NOP_INSTR);
                    arb_err_d    = 1'b1;
                end
                if (wait_done) begin
                    core_rvalid_d[gnt_idx_q] = 1'b1;
                    rr_ptr_d = IDX_W'(wrap_inc(32'(gnt_idx_q), NUM_CORES));
                end
`ifdef IMEM_ARB_TIMEOUT_EN
                else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            default: ;
        endcase
    end

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.core_rdata  = core_rdata_q;
    assign bus.core_rvalid = core_rvalid_q;
    assign bus.core_stall  = bus.core_req & ~core_rvalid_q;
    assign bus.arb_err     = arb_err_q;

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_fetch_arbiter
// Directed scenarios with literal expectations, then randomized cores and
// memory latency, all checked every cycle against a transaction-level model.
// -----------------------------------------------------------------------------
module tb_imem_fetch_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imem_fetch_arbiter_if #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    imem_fetch_arbiter #(
        .NUM_CORES (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .TIMEOUT   (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    bit              m_busy;
    int unsigned     m_owner, m_ptr, m_wait;
    logic [N-1:0]    m_rvalid;
    logic            m_mem_req;
    logic [AW-1:0]   m_mem_addr;
    logic [DW-1:0]   m_rdata;
    logic            m_err;

    initial begin : model
        logic [N-1:0] served_now;
        int unsigned  c;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_busy = 0; m_owner = 0; m_ptr = 0; m_wait = 0;
                m_rvalid = '0; m_mem_req = 1'b0; m_mem_addr = '0;
                m_rdata = 32'h0000_0013; m_err = 1'b0;
            end else begin
                served_now = m_rvalid;
                m_rvalid   = '0;
                m_mem_req  = 1'b0;
                if (!m_busy) begin
                    for (int unsigned k = 0; k < N; k++) begin
                        c = (m_ptr + k) % N;
                        if (!m_busy && bus.core_req[c] && !served_now[c]) begin
                            m_busy = 1; m_owner = c; m_wait = 0; m_mem_req = 1'b1;
                            m_mem_addr = bus.core_addr[c*AW +: AW];
                        end
                    end
                end else if (bus.mem_rvalid) begin
                    m_rdata  = bus.mem_rdata;
                    m_rvalid = N'(1) << m_owner;
                    m_ptr    = (m_owner + 1) % N;
                    m_busy   = 0;
                end else begin
                    m_wait++;
`ifdef IMEM_ARB_TIMEOUT_EN
                    if (m_wait == TO) begin
                        m_rdata  = 32'h0000_0013;
                        m_rvalid = N'(1) << m_owner;
                        m_ptr    = (m_owner + 1) % N;
                        m_busy   = 0;
                        m_err    = 1'b1;
                    end
`endif
                end
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    initial begin : compare
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("mem_req",     64'(bus.mem_req),     64'(m_mem_req));
                chk("mem_addr",    64'(bus.mem_addr),    64'(m_mem_addr));
                chk("core_rvalid", 64'(bus.core_rvalid), 64'(m_rvalid));
                chk("core_rdata",  64'(bus.core_rdata),  64'(m_rdata));
                chk("core_stall",  64'(bus.core_stall),  64'(bus.core_req & ~m_rvalid));
                chk("arb_err",     64'(bus.arb_err),     64'(m_err));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    bit            auto_mem   = 1'b1;
    bit            lat_rand   = 1'b0;
    bit            fixed_en   = 1'b1;
    bit            stray_en   = 1'b0;
    int unsigned   fixed_lat  = 1;
    logic [DW-1:0] fixed_data = 32'hDEAD_BEEF;
    int unsigned   pend       = 0;

    task automatic respond();
        bus.mem_rvalid = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = fixed_en ? fixed_data : $urandom;
            end
        end else if (stray_en && !bus.mem_req && !m_busy && $urandom_range(0, 9) == 0) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = $urandom;
        end
        if (bus.mem_req) pend = lat_rand ? $urandom_range(1, 4) : fixed_lat;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_mem) respond();
    endtask

    task automatic set_req(input logic [N-1:0] r);
        bus.core_req = r;
        #1;
    endtask

    task automatic do_reset();
        bus.core_req   = '0;
        bus.mem_rvalid = 1'b0;
        pend  = 0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    logic [AW-1:0] got [8];
    int            ng, cnt0, cnt1;

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bus.core_req   = '0;
        bus.core_addr  = '0;
        bus.mem_rdata  = '0;
        bus.mem_rvalid = 1'b0;
        tick();
        chk_en = 1'b1;
        do_reset();

        // Single requester, memory answers one cycle after mem_req
        tick();  // cycle 0
        bus.core_addr[0*AW +: AW] = 32'h100;
        set_req(2'b01);
        chk("t1_stall_c0", 64'(bus.core_stall), 64'h1);
        chk("t1_noreq_c0", 64'(bus.mem_req), 64'h0);
        tick();  // cycle 1
        chk("t1_memreq_c1", 64'(bus.mem_req), 64'h1);
        chk("t1_memaddr_c1", 64'(bus.mem_addr), 64'h100);
        chk("t1_stall_c1", 64'(bus.core_stall), 64'h1);
        tick();  // cycle 2
        chk("t1_stall_c2", 64'(bus.core_stall), 64'h1);
        chk("t1_rvalid_c2", 64'(bus.core_rvalid), 64'h0);
        tick();  // cycle 3
        chk("t1_rvalid_c3", 64'(bus.core_rvalid), 64'h1);
        chk("t1_rdata_c3", 64'(bus.core_rdata), 64'hDEAD_BEEF);
        chk("t1_stall_c3", 64'(bus.core_stall), 64'h0);
        tick();  // cycle 4
        set_req(2'b00);
        chk("t1_noregrant_c4", 64'(bus.mem_req), 64'h0);

        // Simultaneous requests from rr_ptr = 0
        do_reset();
        tick();  // cycle 0
        bus.core_addr[0*AW +: AW] = 32'h100;
        bus.core_addr[1*AW +: AW] = 32'h200;
        set_req(2'b11);
        chk("t2_stall_c0", 64'(bus.core_stall), 64'h3);
        tick();  // cycle 1
        chk("t2_addr0_c1", 64'(bus.mem_addr), 64'h100);
        chk("t2_memreq_c1", 64'(bus.mem_req), 64'h1);
        tick();  // cycle 2
        tick();  // cycle 3
        chk("t2_rvalid0_c3", 64'(bus.core_rvalid), 64'h1);
        chk("t2_stall_c3", 64'(bus.core_stall), 64'h2);
        tick();  // cycle 4
        set_req(2'b10);
        chk("t2_memreq_c4", 64'(bus.mem_req), 64'h1);
        chk("t2_addr1_c4", 64'(bus.mem_addr), 64'h200);
        chk("t2_stall_c4", 64'(bus.core_stall), 64'h2);
        tick();  // cycle 5
        chk("t2_stall_c5", 64'(bus.core_stall), 64'h2);
        tick();  // cycle 6
        chk("t2_rvalid1_c6", 64'(bus.core_rvalid), 64'h2);
        chk("t2_stall_c6", 64'(bus.core_stall), 64'h0);

        // Continuous requests from both cores alternate grants
        do_reset();
        tick();
        set_req(2'b11);
        ng = 0;
        for (int t = 0; t < 80 && ng < 8; t++) begin
            tick();
            if (bus.mem_req) begin
                got[ng] = bus.mem_addr;
                ng++;
            end
        end
        chk("t3_grants", 64'(ng), 64'd8);
        cnt0 = 0;
        cnt1 = 0;
        for (int i = 0; i < ng; i++) begin
            chk($sformatf("t3_grant%0d", i), 64'(got[i]), (i % 2 == 0) ? 64'h100 : 64'h200);
            if (got[i] == 32'h100) cnt0++;
            if (got[i] == 32'h200) cnt1++;
        end
        chk("t3_balance", 64'((cnt0 - cnt1 <= 1) && (cnt1 - cnt0 <= 1)), 64'h1);

        // Core0 drops its request while its fetch is in flight
        do_reset();
        fixed_lat = 3;
        tick();  // cycle 0
        set_req(2'b01);
        tick();  // cycle 1
        chk("t4_memreq_c1", 64'(bus.mem_req), 64'h1);
        tick();  // cycle 2
        set_req(2'b00);
        chk("t4_memreq_c2", 64'(bus.mem_req), 64'h0);
        tick();  // cycle 3
        chk("t4_memreq_c3", 64'(bus.mem_req), 64'h0);
        tick();  // cycle 4
        chk("t4_memreq_c4", 64'(bus.mem_req), 64'h0);
        tick();  // cycle 5
        chk("t4_rvalid_c5", 64'(bus.core_rvalid), 64'h1);
        tick();  // cycle 6
        chk("t4_memreq_c6", 64'(bus.mem_req), 64'h0);
        set_req(2'b11);
        tick();  // cycle 7: pointer has moved to core1
        chk("t4_ptr_grant1", 64'(bus.mem_req), 64'h1);
        chk("t4_ptr_addr", 64'(bus.mem_addr), 64'h200);
        fixed_lat = 1;

        // Reset in WAIT, stale mem_rvalid afterwards
        do_reset();
        auto_mem = 1'b0;
        tick();  // cycle 0
        set_req(2'b01);
        tick();  // cycle 1
        chk("t5_memreq_c1", 64'(bus.mem_req), 64'h1);
        tick();  // cycle 2
        rst_n = 1'b0;
        set_req(2'b00);
        chk("t5_rst_memreq", 64'(bus.mem_req), 64'h0);
        chk("t5_rst_memaddr", 64'(bus.mem_addr), 64'h0);
        chk("t5_rst_rdata", 64'(bus.core_rdata), 64'h13);
        chk("t5_rst_rvalid", 64'(bus.core_rvalid), 64'h0);
        chk("t5_rst_err", 64'(bus.arb_err), 64'h0);
        chk("t5_rst_stall", 64'(bus.core_stall), 64'h0);
        tick();  // cycle 3
        rst_n          = 1'b1;
        bus.mem_rdata  = 32'h0BAD_0BAD;
        bus.mem_rvalid = 1'b1;
        tick();  // cycle 4
        bus.mem_rvalid = 1'b0;
        #1;
        chk("t5_stale_rvalid", 64'(bus.core_rvalid), 64'h0);
        chk("t5_stale_rdata", 64'(bus.core_rdata), 64'h13);
        chk("t5_stale_memreq", 64'(bus.mem_req), 64'h0);

`ifdef IMEM_ARB_TIMEOUT_EN
        // Memory never answers
        do_reset();
        tick();  // cycle 0
        bus.core_addr[0*AW +: AW] = 32'h300;
        set_req(2'b01);
        tick();  // cycle 1: first WAIT cycle
        chk("t6_memreq", 64'(bus.mem_req), 64'h1);
        for (int k = 2; k <= 64; k++) tick();
        chk("t6_rvalid_early", 64'(bus.core_rvalid), 64'h0);
        tick();  // cycle 65
        chk("t6_rvalid", 64'(bus.core_rvalid), 64'h1);
        chk("t6_rdata", 64'(bus.core_rdata), 64'h13);
        chk("t6_err", 64'(bus.arb_err), 64'h1);
        set_req(2'b00);
        for (int k = 0; k < 5; k++) tick();
        chk("t6_err_sticky", 64'(bus.arb_err), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("t6_err_cleared", 64'(bus.arb_err), 64'h0);
        tick();
        rst_n = 1'b1;
`endif

        // Randomized traffic
        auto_mem = 1'b1;
        lat_rand = 1'b1;
        fixed_en = 1'b0;
        stray_en = 1'b1;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            if (!rst_n) begin
                rst_n = 1'b1;
            end else if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (bus.core_req[i]) begin
                    if (m_rvalid[i]) begin
                        if ($urandom_range(0, 9) < 7) bus.core_addr[i*AW +: AW] = $urandom & 32'hFFFF_FFFC;
                        else bus.core_req[i] = 1'b0;
                    end else if ($urandom_range(0, 49) == 0) begin
                        bus.core_req[i] = 1'b0;
                    end else if ($urandom_range(0, 29) == 0) begin
                        bus.core_addr[i*AW +: AW] = $urandom & 32'hFFFF_FFFC;
                    end
                end else if ($urandom_range(0, 9) < 4) begin
                    bus.core_req[i] = 1'b1;
                    bus.core_addr[i*AW +: AW] = $urandom & 32'hFFFF_FFFC;
                end
            end
        end
        rst_n = 1'b1;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_fetch_arbiter.md
Name: imem_fetch_arbiter

Overview:
- Shares one single-ported instruction memory between NUM_CORES fetch units.
- Arbitration is round-robin, one fetch in flight at a time.
- Returns fetched instructions to the winning core.
- Drives a per-core stall that freezes that core's PC and IF/ID pipeline register until its fetch completes.

Parameters:
- NUM_CORES, 2, number of requesting cores (2..8).
- ADDR_W, 32, fetch address width.
- DATA_W, 32, instruction width.
- TIMEOUT, 64, WAIT-state cycle limit (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- core_req  in  NUM_CORES  per-core fetch request. Held high with a stable address until core_rvalid.
- core_addr  in  NUM_CORES*ADDR_W  per-core PC. Core i occupies bits [i*ADDR_W +: ADDR_W].
- core_rdata  out  DATA_W  fetched instruction, broadcast to all cores. Qualified by core_rvalid.
- core_rvalid  out  NUM_CORES  one-cycle pulse to the core whose fetch completed.
- core_stall  out  NUM_CORES  freeze for that core's PC and IF/ID register.
- mem_req  out  1  one-cycle memory read strobe.
- mem_addr  out  ADDR_W  memory read address.
- mem_rdata  in  DATA_W  memory read data.
- mem_rvalid  in  1  memory data valid, at least 1 cycle after mem_req.
- arb_err  out  1  sticky timeout flag. Tied 0 without the optional feature.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, rr_ptr=0, gnt_idx=0.
  - mem_req=0, mem_addr=0.
  - core_rdata=32'h00000013 (NOP), core_rvalid=0, arb_err=0.
- core_stall[i] = core_req[i] & ~core_rvalid[i]. This is combinational from registered state.
- State IDLE:
  - Eligible set = core_req masked by core_rvalid; a core is not re-granted in its own completion cycle.
  - Pick the first eligible index searching from rr_ptr upward, with wrap-around modulo NUM_CORES.
  - On grant, register: gnt_idx; mem_addr=core_addr[gnt]; mem_req=1 for exactly one cycle.
  - Then go to WAIT.
  - No eligible request: stay in IDLE, mem_req=0.
- State WAIT:
  - mem_req=0.
  - On mem_rvalid: core_rdata<=mem_rdata; core_rvalid<=one-hot(gnt_idx) for one cycle; rr_ptr<=(gnt_idx+1) mod NUM_CORES; go to IDLE.
- Latency with memory rvalid one cycle after mem_req:
  - req seen in cycle 0; mem_req in cycle 1; mem_rvalid in cycle 2; core_rvalid in cycle 3.
  - Minimum 3 cycles request to data.
  - Back-to-back grants: the completion cycle (IDLE) can grant the next core immediately.
- Simultaneous requests: the rr_ptr order decides. The loser keeps its stall high until it is served. There is no starvation; worst-case wait is NUM_CORES-1 transactions.
- Requester drops core_req mid-transaction (e.g. branch flush):
  - The transaction completes; core_rvalid still pulses and the core ignores it.
  - rr_ptr still advances.
- mem_rvalid arriving in IDLE is ignored, covering stale data after a mid-operation reset.
- Address is sampled only at grant. Later changes to core_addr do not affect the transaction in flight.

Optional Feature:
- Macro: IMEM_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT. After TIMEOUT cycles without mem_rvalid, it forces completion.
  - Forced completion returns core_rdata=32'h00000013 with core_rvalid to gnt_idx, sets arb_err (sticky until reset), and goes to IDLE.
- Undefined: no counter, WAIT is unbounded, arb_err=0.

Decomposition:
- Shared package cpu_pkg: NOP_INSTR=32'h00000013, arbiter state encoding (IDLE, WAIT), default widths.
- One sub-module, rr_arbiter: a combinational round-robin picker (req vector, ptr) -> (valid, grant index). It is reused later for data-memory sharing.

Test Plan:
- Single core, NUM_CORES=2, core_req=2'b01, addr0=0x100, memory rvalid +1, rdata=0xDEADBEEF:
  - mem_req in cycle 1 with mem_addr=0x100.
  - core_rvalid=2'b01 in cycle 3 with core_rdata=0xDEADBEEF.
  - core_stall[0]=1 in cycles 0-2 and 0 in cycle 3.
- Both cores request at cycle 0, rr_ptr=0, addr0=0x100, addr1=0x200:
  - Core0 is served first.
  - Core1 is granted in core0's completion cycle with mem_addr=0x200.
  - core_stall[1] stays high until its core_rvalid.
- Both cores request continuously for 8 transactions: grants strictly alternate 0,1,0,1. Grant counts are equal ±1.
- Core0 drops core_req in WAIT:
  - core_rvalid[0] still pulses.
  - rr_ptr=1.
  - No second mem_req for core0.
- rst_n pulled low in WAIT, then mem_rvalid after release:
  - All outputs return to reset values.
  - The stale mem_rvalid produces no core_rvalid.
- With IMEM_ARB_TIMEOUT_EN, TIMEOUT=64, memory never responds:
  - At WAIT cycle 64, core_rvalid pulses with core_rdata=0x00000013.
  - arb_err=1 and stays 1 until reset.
